pc_sequencer: RTL and testbench

Instruction sequencer for the 9-bit accumulator core. Owns the program counter, steps one instruction per cycle, applies taken branches from the branch-target lookup table, and stalls the core on data-memory LOAD/STORE until memory acknowledges. It sits between the instruction ROM and the decoder. It emits `retire`, which gates all architectural writes (register file, flags).

---
 rtl/seq_pkg.sv | 25 ++
 rtl/pc_sequencer_if.sv | 41 ++++
 rtl/seq_cycle_counter.sv | 39 +++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the pc_sequencer block.
//
// Contents:
//   INST_W       - instruction word width of the accumulator core
//   HALT_OPCODE  - value of inst[8:5] that stops the sequencer
//   seq_state_t  - sequencer states (IDLE, RUN, MEM_WAIT, HALTED)
//   is_halt()    - HALT decode on the top opcode nibble
package seq_pkg;

  localparam int INST_W = 9;
  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT,
    HALTED
  } seq_state_t;

  // Only the opcode nibble is passed in, so callers slice inst[8:5].
  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction/data-memory handshake bundle between the sequencer, the
// instruction ROM / decoder and data memory.
//
// Signals:
//   pc              - current instruction address (sequencer -> ROM)
//   inst            - instruction at pc, combinational ROM read
//   branch_en       - decoder: current branch is taken
//   branch_target   - LUT target for inst[4:0]
//   memory_read_en  - decoder: LOAD
//   memory_write_en - decoder: STORE
//   mem_ack         - data memory completes the access this cycle
//   mem_req         - data-memory access request (sequencer -> memory)
//   retire          - current instruction commits this cycle
//
// Modports: master = sequencer side, slave = core / memory side.
interface pc_sequencer_if #(
  parameter int PC_W = 10
);
  import seq_pkg::*;

  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic              branch_en;
  logic [PC_W-1:0]   branch_target;
  logic              memory_read_en;
  logic              memory_write_en;
  logic              mem_ack;
  logic              mem_req;
  logic              retire;

  modport master (
    output pc, mem_req, retire,
    input  inst, branch_en, branch_target, memory_read_en, memory_write_en, mem_ack
  );

  modport slave (
    input  pc, mem_req, retire,
    output inst, branch_en, branch_target, memory_read_en, memory_write_en, mem_ack
  );

endinterface

// File: rtl/seq_cycle_counter.sv
// Saturating 32-bit busy-cycle counter for the pc_sequencer.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - zero the counter (a new program is starting)
//   inc        - count this cycle (sequencer busy)
//   count      - current count, sticks at 0xFFFF_FFFF
module seq_cycle_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Clear wins over increment; the counter never rolls back to zero by itself.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer for the 9-bit accumulator core. Owns the program
// counter, advances one instruction per cycle, applies taken branches and
// stalls on LOAD/STORE until data memory acknowledges. retire gates all
// architectural writes downstream.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   start       - pulse, begins execution at START_PC from IDLE or HALTED
//   bus         - pc_sequencer_if master (pc, inst, branch, memory handshake, retire)
//   busy        - high in RUN and MEM_WAIT
//   done        - high in HALTED
//   cycle_count - busy-cycle counter, present only with PC_SEQ_CYCLE_COUNT_EN
//
// Build option: define PC_SEQ_CYCLE_COUNT_EN to add the cycle_count output.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int START_PC = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  pc_sequencer_if.master      bus,
`ifdef PC_SEQ_CYCLE_COUNT_EN
  output logic [31:0]         cycle_count,
`endif
  output logic                busy,
  output logic                done
);

  localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  seq_state_t      state_q;
  seq_state_t      state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_inc;
  logic            mem_op;
  logic            halt_inst;
  logic            mem_req;
  logic            retire;

  // pc+1 wraps naturally at the PC_W boundary.
  assign pc_inc    = pc_q + PC_ONE;
  assign mem_op    = bus.memory_read_en | bus.memory_write_en;
  assign halt_inst = is_halt(bus.inst[INST_W-1:INST_W-4]);

  // In RUN the order is HALT, then memory op, then branch/sequential, so a
  // stray branch_en alongside a memory op is ignored. mem_req and retire are
  // purely combinational so an async reset drops them immediately.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mem_req = 1'b0;
    retire  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d    = START_PC_V;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (halt_inst) begin
          state_d = HALTED;
        end else if (mem_op) begin
          mem_req = 1'b1;
          if (bus.mem_ack) begin
            retire = 1'b1;
            pc_d   = pc_inc;
          end else begin
            state_d = MEM_WAIT;
          end
        end else begin
          retire = 1'b1;
          pc_d   = bus.branch_en ? bus.branch_target : pc_inc;
        end
      end
      MEM_WAIT: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          retire  = 1'b1;
          pc_d    = pc_inc;
          state_d = RUN;
        end
      end
      HALTED: begin
        done = 1'b1;
        if (start) begin
          pc_d    = START_PC_V;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= START_PC_V;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.mem_req = mem_req;
  assign bus.retire  = retire;

`ifdef PC_SEQ_CYCLE_COUNT_EN
  // A start is only accepted from IDLE or HALTED, which is when the count restarts.
  logic count_clear;
  assign count_clear = start && ((state_q == IDLE) || (state_q == HALTED));

  seq_cycle_counter u_cycle_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (count_clear),
    .inc   (busy),
    .count (cycle_count)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of directed vectors, a few
// hand-built multi-cycle sequences (memory stalls, wrap, async reset) and a
// randomized run against a behavioural reference model.
module tb_pc_sequencer;
  import seq_pkg::*;

  localparam int PC_W = 10;
  localparam logic [8:0] ALU  = 9'h005;
  localparam logic [8:0] LOAD = 9'h031;
  localparam logic [8:0] HALT = 9'h1E0;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [31:0] cycle_count;
`endif

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(.PC_W(PC_W), .START_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
`ifdef PC_SEQ_CYCLE_COUNT_EN
    .cycle_count (cycle_count),
`endif
    .busy        (busy),
    .done        (done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       start;
    logic [8:0] inst;
    logic       br;
    logic [9:0] tgt;
    logic       rd;
    logic       wr;
    logic       ack;
    logic [9:0] e_pc;
    logic       e_mr;
    logic       e_ret;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: whether a program is executing, stalled on memory, or finished.
  bit          m_active;
  bit          m_waiting;
  bit          m_halted;
  int          m_pc;
  logic [31:0] m_cyc;

  function automatic vec_t mk(input logic s, input logic [8:0] i, input logic b,
                              input logic [9:0] t, input logic rd, input logic wr,
                              input logic ack, input logic [9:0] pc, input logic mr,
                              input logic ret, input logic bsy, input logic dn);
    vec_t v;
    v.start = s; v.inst = i; v.br = b; v.tgt = t; v.rd = rd; v.wr = wr; v.ack = ack;
    v.e_pc = pc; v.e_mr = mr; v.e_ret = ret; v.e_busy = bsy; v.e_done = dn;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start               = v.start;
    bus.inst            = v.inst;
    bus.branch_en       = v.br;
    bus.branch_target   = v.tgt;
    bus.memory_read_en  = v.rd;
    bus.memory_write_en = v.wr;
    bus.mem_ack         = v.ack;
  endtask

  // Called at posedge+1: drive, sample at the falling edge, move to the next posedge+1.
  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    #4;
    checkOutput({tag, " pc"},      32'(bus.pc),      32'(v.e_pc));
    checkOutput({tag, " mem_req"}, 32'(bus.mem_req), 32'(v.e_mr));
    checkOutput({tag, " retire"},  32'(bus.retire),  32'(v.e_ret));
    checkOutput({tag, " busy"},    32'(busy),        32'(v.e_busy));
    checkOutput({tag, " done"},    32'(done),        32'(v.e_done));
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(mk(0, 9'h0, 0, 10'h0, 0, 0, 0, 10'h0, 0, 0, 0, 0));
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[18];

  initial begin
    rst_n = 1'b1;
    applyStimulus(mk(0, 9'h0, 0, 10'h0, 0, 0, 0, 10'h0, 0, 0, 0, 0));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset pc",      32'(bus.pc),      32'h0);
    checkOutput("reset mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("reset retire",  32'(bus.retire),  32'h0);
    checkOutput("reset busy",    32'(busy),        32'h0);
    checkOutput("reset done",    32'(done),        32'h0);
`ifdef PC_SEQ_CYCLE_COUNT_EN
    checkOutput("reset cycle_count", cycle_count, 32'h0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: three ALU ops + HALT, taken branch, not-taken branch, start ignored in RUN.
    //             start inst br tgt   rd wr ack   pc    mr ret busy done
    tbl[0]  = mk(1, ALU,  0, 10'h0,  0, 0, 0, 10'h000, 0, 0, 0, 0);
    tbl[1]  = mk(0, ALU,  0, 10'h0,  0, 0, 0, 10'h000, 0, 1, 1, 0);
    tbl[2]  = mk(0, ALU,  0, 10'h0,  0, 0, 0, 10'h001, 0, 1, 1, 0);
    tbl[3]  = mk(0, ALU,  0, 10'h0,  0, 0, 0, 10'h002, 0, 1, 1, 0);
    tbl[4]  = mk(0, HALT, 0, 10'h0,  0, 0, 0, 10'h003, 0, 0, 1, 0);
    tbl[5]  = mk(0, ALU,  0, 10'h0,  0, 0, 1, 10'h003, 0, 0, 0, 1);
    tbl[6]  = mk(1, ALU,  0, 10'h0,  0, 0, 0, 10'h003, 0, 0, 0, 1);
    tbl[7]  = mk(0, ALU,  0, 10'h0,  0, 0, 0, 10'h000, 0, 1, 1, 0);
    tbl[8]  = mk(0, ALU,  0, 10'h0,  0, 0, 0, 10'h001, 0, 1, 1, 0);
    tbl[9]  = mk(0, ALU,  1, 10'h40, 0, 0, 0, 10'h002, 0, 1, 1, 0);
    tbl[10] = mk(0, ALU,  0, 10'h0,  0, 0, 0, 10'h040, 0, 1, 1, 0);
    tbl[11] = mk(0, HALT, 0, 10'h0,  0, 0, 0, 10'h041, 0, 0, 1, 0);
    tbl[12] = mk(1, ALU,  0, 10'h0,  0, 0, 0, 10'h041, 0, 0, 0, 1);
    tbl[13] = mk(0, ALU,  0, 10'h0,  0, 0, 0, 10'h000, 0, 1, 1, 0);
    tbl[14] = mk(0, ALU,  0, 10'h0,  0, 0, 1, 10'h001, 0, 1, 1, 0);
    tbl[15] = mk(0, ALU,  0, 10'h40, 0, 0, 0, 10'h002, 0, 1, 1, 0);
    tbl[16] = mk(1, ALU,  0, 10'h0,  0, 0, 0, 10'h003, 0, 1, 1, 0);
    tbl[17] = mk(0, HALT, 0, 10'h0,  0, 0, 0, 10'h004, 0, 0, 1, 0);
    for (int i = 0; i < 18; i++) begin
      runVector(tbl[i], $sformatf("vec%0d", i));
`ifdef PC_SEQ_CYCLE_COUNT_EN
      if (i == 5) checkOutput("halt cycle_count", cycle_count, 32'd4);
`endif
    end

    // LOAD at pc 5 with a 3-cycle ack delay, then same-cycle STORE, then memory op beside a branch.
    runVector(mk(1, ALU,  0, 10'h0,   0, 0, 0, 10'h004, 0, 0, 0, 1), "seqA start");
    for (int i = 0; i < 5; i++)
      runVector(mk(0, ALU, 0, 10'h0, 0, 0, 0, 10'(i), 0, 1, 1, 0), $sformatf("seqA alu%0d", i));
    runVector(mk(0, LOAD, 0, 10'h0,   1, 0, 0, 10'h005, 1, 0, 1, 0), "seqA load");
    runVector(mk(0, LOAD, 0, 10'h0,   1, 0, 0, 10'h005, 1, 0, 1, 0), "seqA wait1");
    runVector(mk(0, LOAD, 0, 10'h0,   1, 0, 0, 10'h005, 1, 0, 1, 0), "seqA wait2");
    runVector(mk(0, LOAD, 0, 10'h0,   1, 0, 1, 10'h005, 1, 1, 1, 0), "seqA ack");
    runVector(mk(0, LOAD, 0, 10'h0,   0, 1, 1, 10'h006, 1, 1, 1, 0), "seqA store");
    runVector(mk(0, ALU,  0, 10'h0,   0, 0, 0, 10'h007, 0, 1, 1, 0), "seqA after store");
    runVector(mk(0, LOAD, 1, 10'h100, 1, 0, 1, 10'h008, 1, 1, 1, 0), "seqA mem+branch");

    // Wrap at 0x3FF with start ignored in RUN, then start ignored in MEM_WAIT.
    runVector(mk(0, ALU,  1, 10'h3FF, 0, 0, 0, 10'h009, 0, 1, 1, 0), "seqB to 3FF");
    runVector(mk(1, ALU,  0, 10'h0,   0, 0, 0, 10'h3FF, 0, 1, 1, 0), "seqB wrap");
    runVector(mk(0, ALU,  0, 10'h0,   0, 0, 0, 10'h000, 0, 1, 1, 0), "seqB at 0");
    runVector(mk(0, LOAD, 0, 10'h0,   1, 0, 0, 10'h001, 1, 0, 1, 0), "seqB load");
    runVector(mk(1, LOAD, 0, 10'h0,   1, 0, 0, 10'h001, 1, 0, 1, 0), "seqB wait start");
    runVector(mk(0, LOAD, 0, 10'h0,   1, 0, 1, 10'h001, 1, 1, 1, 0), "seqB ack");
    runVector(mk(0, ALU,  0, 10'h0,   0, 0, 0, 10'h002, 0, 1, 1, 0), "seqB alu");

    // Asynchronous reset in the middle of a memory stall.
    runVector(mk(0, LOAD, 0, 10'h0,   1, 0, 0, 10'h003, 1, 0, 1, 0), "seqC load");
    applyStimulus(mk(0, LOAD, 0, 10'h0, 1, 0, 0, 10'h0, 0, 0, 0, 0));
    #1 checkOutput("seqC waiting mem_req", 32'(bus.mem_req), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("seqC async mem_req", 32'(bus.mem_req), 32'h0);
    checkOutput("seqC async pc",      32'(bus.pc),      32'h0);
    checkOutput("seqC async busy",    32'(busy),        32'h0);
    checkOutput("seqC async retire",  32'(bus.retire),  32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    runVector(mk(1, ALU,  0, 10'h0,   0, 0, 0, 10'h000, 0, 0, 0, 0), "seqC start");
    runVector(mk(0, ALU,  0, 10'h0,   0, 0, 0, 10'h000, 0, 1, 1, 0), "seqC alu0");
    runVector(mk(0, ALU,  0, 10'h0,   0, 0, 0, 10'h001, 0, 1, 1, 0), "seqC alu1");

    // Randomized run against the reference model.
    doReset();
    m_active = 0; m_waiting = 0; m_halted = 0; m_pc = 0; m_cyc = 0;
    begin
      vec_t v;
      v = mk(0, ALU, 0, 10'h0, 0, 0, 0, 10'h0, 0, 0, 0, 0);
      for (int n = 0; n < 600; n++) begin
        logic is_h;
        logic is_m;
        v.start = ($urandom_range(0, 7) == 0);
        v.br    = $urandom_range(0, 1);
        v.tgt   = ($urandom_range(0, 5) == 0) ? 10'h3FF : 10'($urandom);
        v.ack   = ($urandom_range(0, 2) == 0);
        if (!m_waiting) begin
          v.inst = 9'($urandom);
          if ($urandom_range(0, 9) == 0) v.inst[8:5] = 4'hF;
          else if (v.inst[8:5] == 4'hF) v.inst[8:5] = 4'h0;
          v.rd = ($urandom_range(0, 3) == 0);
          v.wr = ($urandom_range(0, 4) == 0);
        end
        is_h = (v.inst[8:5] == 4'hF);
        is_m = v.rd | v.wr;
        v.e_pc   = 10'(m_pc);
        v.e_busy = m_active;
        v.e_done = m_halted;
        v.e_mr   = m_active && (m_waiting || (!is_h && is_m));
        v.e_ret  = m_active && (m_waiting ? v.ack : (!is_h && (!is_m || v.ack)));
        applyStimulus(v);
        #4;
        checkOutput($sformatf("rnd%0d pc", n),      32'(bus.pc),      32'(v.e_pc));
        checkOutput($sformatf("rnd%0d mem_req", n), 32'(bus.mem_req), 32'(v.e_mr));
        checkOutput($sformatf("rnd%0d retire", n),  32'(bus.retire),  32'(v.e_ret));
        checkOutput($sformatf("rnd%0d busy", n),    32'(busy),        32'(v.e_busy));
        checkOutput($sformatf("rnd%0d done", n),    32'(done),        32'(v.e_done));
`ifdef PC_SEQ_CYCLE_COUNT_EN
        checkOutput($sformatf("rnd%0d cycle_count", n), cycle_count, m_cyc);
`endif
        // Advance the model by one cycle.
        if (m_active && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
        if (!m_active) begin
          if (v.start) begin
            m_pc = 0; m_active = 1; m_halted = 0; m_waiting = 0; m_cyc = 0;
          end
        end else if (m_waiting) begin
          if (v.ack) begin
            m_waiting = 0;
            m_pc = (m_pc + 1) % 1024;
          end
        end else if (is_h) begin
          m_active = 0;
          m_halted = 1;
        end else if (is_m) begin
          if (v.ack) m_pc = (m_pc + 1) % 1024;
          else m_waiting = 1;
        end else begin
          m_pc = v.br ? int'(v.tgt) : (m_pc + 1) % 1024;
        end
        @(posedge clk);
        #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
